traffic_ctrl: RTL and testbench
===============================

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000000, clock cycles per one-second tick (>=2).
REQ-002 Parameter T_MAIN_GREEN, default 30, main-road green duration in seconds (1..59).
REQ-003 Parameter T_SIDE_GREEN, default 20, side-road green duration in seconds (1..59).
REQ-004 Parameter T_YELLOW, default 3, yellow duration in seconds for both roads (1..59).
REQ-005 clk  input  1  system clock; the block has one clock.
REQ-006 rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-007 en  input  1  run enable; low freezes prescaler, countdown and state.
REQ-008 main_light  output  3  main-road lamps {red, yellow, green}, one-hot.
REQ-009 side_light  output  3  side-road lamps {red, yellow, green}, one-hot.
REQ-010 bin  output  6  seconds remaining in the current phase, unsigned, range 1..59; drives the two-digit 7-segment decoder.
REQ-011 phase  output  2  current state encoding: 0 MAIN_GREEN, 1 MAIN_YELLOW, 2 SIDE_GREEN, 3 SIDE_YELLOW.

Function
REQ-012 Prescaler counter div_cnt SHALL count 0..CLK_DIV-1 while en=1, wrap to 0, and assert an internal tick for the one cycle where div_cnt==CLK_DIV-1 and en=1.
REQ-013 State machine SHALL have exactly four states, cycling MAIN_GREEN -> MAIN_YELLOW -> SIDE_GREEN -> SIDE_YELLOW -> MAIN_GREEN; no other transitions.
REQ-014 Phase durations: MAIN_GREEN=T_MAIN_GREEN, MAIN_YELLOW=T_YELLOW, SIDE_GREEN=T_SIDE_GREEN, SIDE_YELLOW=T_YELLOW.
REQ-015 On tick with bin>1: bin SHALL decrement by 1, state unchanged.
REQ-016 On tick with bin==1: state SHALL advance to the next state and bin SHALL load the next state's duration in the same clock edge; bin never shows 0.
REQ-017 Without tick: bin, state and lamp outputs SHALL hold.
REQ-018 Lamp decode: MAIN_GREEN main=001 side=100; MAIN_YELLOW main=010 side=100; SIDE_GREEN main=100 side=001; SIDE_YELLOW main=100 side=010.
REQ-019 Lamp outputs and phase SHALL be a pure decode of the registered state (no extra latency); bin SHALL be a register.
REQ-020 Both roads SHALL never show green or yellow simultaneously in any cycle.
REQ-021 en deasserted mid-count: div_cnt SHALL hold its value (not clear); on re-assertion counting resumes from the held value.
REQ-022 A phase of duration 1 SHALL last exactly one tick period.
REQ-023 Out-of-range parameters (0 or >59) are illegal; behaviour undefined, simulation SHALL flag via elaboration-time check.

Reset
REQ-024 While rst_n=0, asynchronously: state=MAIN_GREEN, bin=T_MAIN_GREEN, div_cnt=0, main_light=001, side_light=100, phase=0.
REQ-025 Reset asserted mid-phase SHALL take effect without a clock edge; first tick after release occurs CLK_DIV enabled cycles after the first rising edge with rst_n=1.

Verification (CLK_DIV=4, T_MAIN_GREEN=5, T_SIDE_GREEN=3, T_YELLOW=2)
REQ-026 Release reset, en=1 -> bin=5, main=001, side=100; bin=4 after 4 clocks, bin=1 after 16 clocks.
REQ-027 Run 48 clocks -> sequence bin 5,4,3,2,1 (MAIN_GREEN), 2,1 (MAIN_YELLOW, main=010), 3,2,1 (SIDE_GREEN, side=001), 2,1 (SIDE_YELLOW, side=010); clock 48 returns to phase=0, bin=5.
REQ-028 Drop en for 10 clocks with div_cnt=2, bin=3 -> bin, phase, div_cnt frozen; after re-enable next decrement occurs 2 clocks later.
REQ-029 Assert rst_n=0 between edges during SIDE_GREEN bin=2 -> outputs immediately main=001, side=100, bin=5, phase=0.
REQ-030 Continuous assertion over 1000 random en patterns -> never (main_light[0]|main_light[1]) & (side_light[0]|side_light[1]); lamps always one-hot; bin always 1..59.
REQ-031 Parameters T_MAIN_GREEN=59, T_YELLOW=1 -> bin loads 59 on wrap; MAIN_YELLOW lasts exactly 4 clocks.

Source files
------------

// File: rtl/traffic_ctrl_if.sv
// rtl/traffic_ctrl_if.sv - enable input plus lamp/countdown outputs of the traffic controller
interface traffic_ctrl_if;
   logic       en;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic [5:0] bin;
   logic [1:0] phase;

   modport master (input en, output main_light, side_light, bin, phase);
   modport slave  (output en, input main_light, side_light, bin, phase);
endinterface

// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-road traffic light sequencer with one-second prescaler and countdown
module traffic_ctrl #(
   parameter int CLK_DIV      = 50000000,
   parameter int T_MAIN_GREEN = 30,
   parameter int T_SIDE_GREEN = 20,
   parameter int T_YELLOW     = 3
) (
   input logic            clk,
   input logic            rst_n,
   traffic_ctrl_if.master bus
);

   generate
      if (CLK_DIV < 2 ||
          T_MAIN_GREEN < 1 || T_MAIN_GREEN > 59 ||
          T_SIDE_GREEN < 1 || T_SIDE_GREEN > 59 ||
          T_YELLOW < 1 || T_YELLOW > 59) begin : g_bad_param
         $error("traffic_ctrl: parameter out of range");
      end
   endgenerate

   localparam int              DW       = $clog2(CLK_DIV);
   localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      MAIN_GREEN  = 2'd0,
      MAIN_YELLOW = 2'd1,
      SIDE_GREEN  = 2'd2,
      SIDE_YELLOW = 2'd3
   } state_t;

   logic [DW-1:0] div_cnt;
   logic          tick;
   state_t        state_q, state_d;
   logic [5:0]    bin_q, bin_d;

   function automatic logic [5:0] duration(input state_t s);
      case (s)
         MAIN_GREEN:  duration = 6'(T_MAIN_GREEN);
         MAIN_YELLOW: duration = 6'(T_YELLOW);
         SIDE_GREEN:  duration = 6'(T_SIDE_GREEN);
         default:     duration = 6'(T_YELLOW);
      endcase
   endfunction

   // en low holds div_cnt where it is so the partial second is not lost
   assign tick = bus.en && (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (bus.en) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MAIN_GREEN;
         bin_q   <= 6'(T_MAIN_GREEN);
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      if (tick) begin
         if (bin_q == 6'd1) begin
            case (state_q)
               MAIN_GREEN:  state_d = MAIN_YELLOW;
               MAIN_YELLOW: state_d = SIDE_GREEN;
               SIDE_GREEN:  state_d = SIDE_YELLOW;
               default:     state_d = MAIN_GREEN;
            endcase
            bin_d = duration(state_d);
         end else begin
            bin_d = bin_q - 6'd1;
         end
      end
   end

   // Lamps decode straight from the state register; red is the default for each road
   always_comb begin
      bus.main_light = 3'b100;
      bus.side_light = 3'b100;
      case (state_q)
         MAIN_GREEN:  bus.main_light = 3'b001;
         MAIN_YELLOW: bus.main_light = 3'b010;
         SIDE_GREEN:  bus.side_light = 3'b001;
         default:     bus.side_light = 3'b010;
      endcase
   end

   assign bus.phase = state_q;
   assign bus.bin   = bin_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - randomized self-checking bench for traffic_ctrl against a tick-count model
module tb_traffic_ctrl;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   ec1;
   int   ec2;

   traffic_ctrl_if ifc();
   traffic_ctrl_if ifc2();

   traffic_ctrl #(.CLK_DIV(4), .T_MAIN_GREEN(5), .T_SIDE_GREEN(3), .T_YELLOW(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   traffic_ctrl #(.CLK_DIV(4), .T_MAIN_GREEN(59), .T_SIDE_GREEN(3), .T_YELLOW(1)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected phase/bin from the number of enabled clocks since reset
   function automatic void model(input int e, input int d0, input int d1, input int d2,
                                 input int d3, output int ph, output int bn);
      int d[4];
      int t;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      t = (e / 4) % (d0 + d1 + d2 + d3);
      ph = 0;
      bn = d0;
      for (int p = 0; p < 4; p++) begin
         if (t < d[p]) begin
            ph = p;
            bn = d[p] - t;
            break;
         end
         t = t - d[p];
      end
   endfunction

   function automatic logic [5:0] lamps(input int ph);
      logic [5:0] tab [4];
      tab[0] = 6'b001_100;
      tab[1] = 6'b010_100;
      tab[2] = 6'b100_001;
      tab[3] = 6'b100_010;
      return tab[ph];
   endfunction

   task automatic step(input logic e1, input logic e2);
      ifc.en  = e1;
      ifc2.en = e2;
      @(posedge clk);
      if (e1) ec1++;
      if (e2) ec2++;
      #1;
   endtask

   task automatic do_reset();
      ifc.en  = 1'b0;
      ifc2.en = 1'b0;
      rst_n   = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      ec1   = 0;
      ec2   = 0;
   endtask

   task automatic test_reset();
      ifc.en  = 1'b1;
      ifc2.en = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ifc.bin !== 6'd5) begin errors++; $display("FAIL reset_bin got=%0d exp=5", ifc.bin); end
      checks++;
      if (ifc.phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", ifc.phase); end
      checks++;
      if ({ifc.main_light, ifc.side_light} !== 6'b001_100) begin
         errors++; $display("FAIL reset_lamps got=%b exp=001100", {ifc.main_light, ifc.side_light});
      end
      checks++;
      if (ifc2.bin !== 6'd59) begin errors++; $display("FAIL reset_bin2 got=%0d exp=59", ifc2.bin); end
      do_reset();
   endtask

   task automatic test_full_cycle();
      int ph, bn;
      do_reset();
      for (int i = 1; i <= 48; i++) begin
         step(1'b1, 1'b0);
         model(ec1, 5, 2, 3, 2, ph, bn);
         checks++;
         if (ifc.phase !== 2'(ph) || ifc.bin !== 6'(bn)) begin
            errors++;
            $display("FAIL cycle_state clk=%0d got phase=%0d bin=%0d exp phase=%0d bin=%0d",
                     i, ifc.phase, ifc.bin, ph, bn);
         end
         checks++;
         if ({ifc.main_light, ifc.side_light} !== lamps(ph)) begin
            errors++;
            $display("FAIL cycle_lamps clk=%0d got=%b exp=%b", i,
                     {ifc.main_light, ifc.side_light}, lamps(ph));
         end
         if (i == 4 || i == 16 || i == 48) begin
            checks++;
            if (ifc.bin !== ((i == 4) ? 6'd4 : (i == 16) ? 6'd1 : 6'd5)) begin
               errors++; $display("FAIL cycle_mark clk=%0d got bin=%0d", i, ifc.bin);
            end
         end
      end
   endtask

   task automatic test_enable_freeze();
      do_reset();
      repeat (10) step(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         checks++;
         if (ifc.bin !== 6'd3 || ifc.phase !== 2'd0) begin
            errors++;
            $display("FAIL freeze_hold i=%0d got bin=%0d phase=%0d exp bin=3 phase=0", i, ifc.bin, ifc.phase);
         end
      end
      step(1'b1, 1'b0);
      checks++;
      if (ifc.bin !== 6'd3) begin errors++; $display("FAIL freeze_resume1 got=%0d exp=3", ifc.bin); end
      step(1'b1, 1'b0);
      checks++;
      if (ifc.bin !== 6'd2) begin errors++; $display("FAIL freeze_resume2 got=%0d exp=2", ifc.bin); end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (33) step(1'b1, 1'b0);
      checks++;
      if (ifc.phase !== 2'd2 || ifc.bin !== 6'd2) begin
         errors++; $display("FAIL async_setup got phase=%0d bin=%0d exp phase=2 bin=2", ifc.phase, ifc.bin);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ifc.main_light, ifc.side_light} !== 6'b001_100 || ifc.bin !== 6'd5 || ifc.phase !== 2'd0) begin
         errors++;
         $display("FAIL async_reset got lamps=%b bin=%0d phase=%0d exp lamps=001100 bin=5 phase=0",
                  {ifc.main_light, ifc.side_light}, ifc.bin, ifc.phase);
      end
      do_reset();
   endtask

   task automatic test_random_en();
      int ph, bn;
      logic e;
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         e = 1'($urandom_range(0, 1));
         step(e, 1'b0);
         model(ec1, 5, 2, 3, 2, ph, bn);
         checks++;
         if (ifc.phase !== 2'(ph) || ifc.bin !== 6'(bn) ||
             {ifc.main_light, ifc.side_light} !== lamps(ph)) begin
            errors++;
            $display("FAIL random_model i=%0d got phase=%0d bin=%0d lamps=%b exp phase=%0d bin=%0d lamps=%b",
                     i, ifc.phase, ifc.bin, {ifc.main_light, ifc.side_light}, ph, bn, lamps(ph));
         end
         checks++;
         if (((ifc.main_light[0] | ifc.main_light[1]) & (ifc.side_light[0] | ifc.side_light[1])) !== 1'b0 ||
             !$onehot(ifc.main_light) || !$onehot(ifc.side_light) ||
             ifc.bin < 6'd1 || ifc.bin > 6'd59) begin
            errors++;
            $display("FAIL random_safety i=%0d got lamps=%b bin=%0d", i,
                     {ifc.main_light, ifc.side_light}, ifc.bin);
         end
      end
   endtask

   task automatic test_extreme_params();
      int ph, bn;
      int yel;
      yel = 0;
      do_reset();
      for (int i = 1; i <= 260; i++) begin
         step(1'b0, 1'b1);
         model(ec2, 59, 1, 3, 1, ph, bn);
         if (ifc2.phase == 2'd1) yel++;
         checks++;
         if (ifc2.phase !== 2'(ph) || ifc2.bin !== 6'(bn)) begin
            errors++;
            $display("FAIL extreme_state clk=%0d got phase=%0d bin=%0d exp phase=%0d bin=%0d",
                     i, ifc2.phase, ifc2.bin, ph, bn);
         end
         if (i == 256) begin
            checks++;
            if (ifc2.bin !== 6'd59 || ifc2.phase !== 2'd0) begin
               errors++; $display("FAIL extreme_wrap got bin=%0d phase=%0d exp bin=59 phase=0", ifc2.bin, ifc2.phase);
            end
         end
      end
      checks++;
      if (yel !== 4) begin errors++; $display("FAIL extreme_yellow_len got=%0d exp=4", yel); end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      ec1     = 0;
      ec2     = 0;
      rst_n   = 1'b0;
      ifc.en  = 1'b0;
      ifc2.en = 1'b0;
      test_reset();
      test_full_cycle();
      test_enable_freeze();
      test_async_reset();
      test_random_en();
      test_extreme_params();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
